pattern_serializer: RTL
=======================

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter WIDTH, default 8, word length in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 is sent first, 0 = bit 0 is sent first.
REQ-003 Parameter IDLE_BIT, default 1, value driven on dout when no word is shifting.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; while 0, all state is held at reset values.
REQ-006 clr  input  1  synchronous flush; discards held and shifting words.
REQ-007 load_data  input  WIDTH  parallel word to serialize.
REQ-008 load_valid  input  1  load_data is valid.
REQ-009 load_ready  output  1  a word can be accepted; equals NOT hold_full, with no combinational path from inputs.
REQ-010 dout  output  1  registered serial bit stream; feeds the downstream pattern detector din.
REQ-011 dout_valid  output  1  registered; dout carries a data bit this cycle.
REQ-012 frame_start  output  1  registered one-cycle pulse, coincident with the first bit of each word.
REQ-013 done  output  1  registered one-cycle pulse, in the cycle after the last bit of a word when no word follows.
REQ-014 busy  output  1  high when state is SHIFT or hold_full is 1.

Function
REQ-015 Storage: one holding register (hold_data, hold_full), one shift register, a bit counter of ceil(log2(WIDTH)) bits, and a state register with states IDLE and SHIFT.
REQ-016 Accept: when load_valid=1 and load_ready=1 at a rising edge, hold_data <= load_data and hold_full <= 1.
REQ-017 A transfer occurs at an edge when hold_full=1 and the block is either in IDLE or in SHIFT with bit_cnt=WIDTH-1.
REQ-018 On a transfer: dout <= first bit of hold_data, dout_valid <= 1, frame_start <= 1, bit_cnt <= 0, state <= SHIFT, hold_full <= 0, and the remaining WIDTH-1 bits load into the shift register.
REQ-019 In SHIFT with bit_cnt<WIDTH-1: dout <= next bit in the MSB_FIRST order, bit_cnt increments, and dout_valid stays 1.
REQ-020 In SHIFT with bit_cnt=WIDTH-1 and hold_full=0: state <= IDLE, dout <= IDLE_BIT, dout_valid <= 0, done <= 1.
REQ-021 Back-to-back operation: when the next word is held at the last-bit edge, its first bit follows the previous word's last bit with zero gap cycles; done does not pulse.
REQ-022 Latency: a word accepted at edge N while IDLE shows its first bit on dout after edge N+1, and its last bit after edge N+WIDTH.
REQ-023 Throughput: one word per WIDTH cycles when load_valid is held high; load_ready reasserts the cycle after each transfer.
REQ-024 In IDLE with hold_full=0: dout=IDLE_BIT, dout_valid=0, and frame_start and done are 0.
REQ-025 clr=1 at an edge: hold_full <= 0, state <= IDLE, dout <= IDLE_BIT, dout_valid <= 0, frame_start <= 0, done <= 0, and any word on load_data is not accepted; clr has priority over accept and transfer.
REQ-026 Changes to load_data while hold_full=1 have no effect on the serialized stream.

Reset
REQ-027 While rst=0: state=IDLE, hold_full=0, bit_cnt=0, shift register=0, dout=IDLE_BIT, dout_valid=0, frame_start=0, done=0, load_ready=1, busy=0.
REQ-028 Assertion of rst mid-word aborts the word immediately, with no done pulse; after release, the first edge may accept a new word.

Verification
REQ-029 WIDTH=8, MSB_FIRST=1; one-cycle load of 8'h55 from IDLE -> dout=0,1,0,1,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; frame_start on the first bit; done 1 cycle after the last bit; the downstream detector dout pulses after the 4th and 6th bits.
REQ-030 MSB_FIRST=0; load 8'hA0 -> dout=0,0,0,0,0,1,0,1 in that order, then dout returns to 1 with dout_valid=0.
REQ-031 load_valid held high with words 8'h0F then 8'hF0 -> 16 contiguous valid bits, frame_start twice 8 cycles apart, done once, and load_ready low only in the cycles where hold_full=1.
REQ-032 clr asserted during bit 3 of 8'hFF, with 8'h00 held -> next cycle dout=1, dout_valid=0, busy=0; 8'h00 is never emitted.
REQ-033 rst driven low asynchronously between edges during bit 5 -> outputs take reset values before the next edge; after release, a new load of 8'h35 serializes correctly.
REQ-034 Random load_valid with random data over 10k cycles; a scoreboard reconstructs words from dout/dout_valid/frame_start -> they match the accepted words in order, and no bit is dropped or duplicated.

Source files
------------

// File: rtl/pattern_serializer.sv
// pattern_serializer
//   Parallel-to-serial converter with a one-word holding register in front of
//   the shift register, so a new word can be queued while the current word is
//   still going out. Words leave back to back, with no gap, while the holding
//   register keeps being refilled.
//
// Parameters
//   WIDTH     word length in bits (2..32)
//   MSB_FIRST 1: bit WIDTH-1 goes out first, 0: bit 0 goes out first
//   IDLE_BIT  level on dout while no word is shifting
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   clr         synchronous flush of the held word and the shifting word
//   load_data   parallel word to serialize
//   load_valid  load_data is valid
//   load_ready  a word can be accepted (registered, NOT hold_full)
//   dout        registered serial bit stream (feeds the pattern detector din)
//   dout_valid  dout carries a data bit this cycle
//   frame_start one-cycle pulse with the first bit of each word
//   done        one-cycle pulse after the last bit when no word follows
//   busy        a word is shifting or held
//
// State | Meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing shifting; dout at IDLE_BIT, waiting for a held word
// SHIFT | a word is on dout; bit_cnt is the index of the current bit
module pattern_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int unsigned    CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_bit;
  logic             transfer;
  logic             first_bit;
  logic [WIDTH-2:0] rest_bits;
  logic             next_bit;
  logic [WIDTH-2:0] shift_adv;

  // Bit ordering is fixed at elaboration: the shift register always presents
  // the next bit at one fixed end and moves away from it.
  if (MSB_FIRST) begin : g_msb
    assign first_bit = hold_data_q[WIDTH-1];
    assign rest_bits = hold_data_q[WIDTH-2:0];
    assign next_bit  = shift_q[WIDTH-2];
    assign shift_adv = shift_q << 1;
  end else begin : g_lsb
    assign first_bit = hold_data_q[0];
    assign rest_bits = hold_data_q[WIDTH-1:1];
    assign next_bit  = shift_q[0];
    assign shift_adv = shift_q >> 1;
  end

  // load_ready depends only on hold_full_q, so accept never needs a
  // combinational path from load_valid back to load_ready.
  assign accept   = load_valid & ~hold_full_q & ~clr;
  assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);
  // A held word moves into the shifter either from IDLE or on the last-bit
  // edge of the previous word, which is what gives zero-gap back-to-back.
  assign transfer = ~clr & hold_full_q & ((state_q == IDLE) | last_bit);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (transfer) begin
      state_d = SHIFT;
    end else if (last_bit) begin
      state_d = IDLE;
    end
  end

  // Output / datapath next values
  always_comb begin
    hold_data_d   = hold_data_q;
    hold_full_d   = hold_full_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    dout_d        = dout_q;
    dout_valid_d  = dout_valid_q;
    frame_start_d = 1'b0;
    done_d        = 1'b0;

    if (clr) begin
      hold_full_d  = 1'b0;
      shift_d      = '0;
      bit_cnt_d    = '0;
      dout_d       = IDLE_BIT;
      dout_valid_d = 1'b0;
    end else begin
      if (accept) begin
        hold_data_d = load_data;
        hold_full_d = 1'b1;
      end

      if (transfer) begin
        hold_full_d   = 1'b0;
        shift_d       = rest_bits;
        bit_cnt_d     = '0;
        dout_d        = first_bit;
        dout_valid_d  = 1'b1;
        frame_start_d = 1'b1;
      end else if (last_bit) begin
        bit_cnt_d    = '0;
        dout_d       = IDLE_BIT;
        dout_valid_d = 1'b0;
        done_d       = 1'b1;
      end else if (state_q == SHIFT) begin
        shift_d      = shift_adv;
        bit_cnt_d    = bit_cnt_q + CW'(1);
        dout_d       = next_bit;
        dout_valid_d = 1'b1;
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_data_q   <= '0;
      hold_full_q   <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      dout_q        <= IDLE_BIT;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      hold_data_q   <= hold_data_d;
      hold_full_q   <= hold_full_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_start_q <= frame_start_d;
      done_q        <= done_d;
    end
  end

  assign load_ready  = ~hold_full_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign frame_start = frame_start_q;
  assign done        = done_q;
  assign busy        = (state_q == SHIFT) | hold_full_q;

endmodule
